// File: rtl/emb_lookup_ctrl.sv
// emb_lookup_ctrl: sequences the embedding-weight ROM for the embedding layer.
// Accepts one character index per handshake, reads EMB_DIM consecutive words
// starting at char*EMB_DIM, gathers the 1-cycle-latency ROM data into a
// packed vector and presents it downstream with valid/ready.
// Optional feature macro: EMB_BOUND_CHECK_EN (out-of-range index check, sticky err).
module emb_lookup_ctrl #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 13,
    parameter int EMB_DIM  = 24,
    parameter int CHAR_NUM = 200,
    parameter int CWIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CWIDTH-1:0]         in_char,
    output logic [AWIDTH-1:0]         rom_addr,
    input  logic [DWIDTH-1:0]         rom_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EMB_DIM*DWIDTH-1:0] out_vec,
    output logic                      busy,
    output logic                      err
);

    localparam int CNT_W = $clog2(EMB_DIM);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(EMB_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [AWIDTH-1:0]           base_q, base_d;
    logic [CNT_W-1:0]            d_q, d_d;
    logic [CNT_W-1:0]            cap_q, cap_d;
    logic                        rd1_q, rd1_d;
    logic                        rd2_q, rd2_d;
    logic [AWIDTH-1:0]           addr_q, addr_d;
    logic [EMB_DIM*DWIDTH-1:0]   vec_q, vec_d;
    logic                        err_q, err_d;
    logic                        accept;
    logic                        oob;

    assign accept = (state_q == S_IDLE) && in_valid;

`ifdef EMB_BOUND_CHECK_EN
    assign oob = (32'(in_char) >= 32'(CHAR_NUM));
`else
    assign oob = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: READ issues addresses, DRAIN waits for the last lane
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = oob ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (d_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd2_q && (cap_q == LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; rd1/rd2 track each issued read through the
    // address register and the ROM so lane capture lines up with rom_q
    always_comb begin
        base_d = base_q;
        d_d    = d_q;
        cap_d  = cap_q;
        addr_d = addr_q;
        vec_d  = vec_q;
        err_d  = err_q;
        rd1_d  = (state_q == S_READ);
        rd2_d  = rd1_q;

        if (accept) begin
            base_d = AWIDTH'(32'(in_char) * 32'(EMB_DIM));
            d_d    = '0;
            cap_d  = '0;
            if (oob) begin
                vec_d = '0;
                err_d = 1'b1;
            end
        end

        if (state_q == S_READ) begin
            addr_d = base_q + AWIDTH'(d_q);
            d_d    = d_q + CNT_W'(1);
        end

        if (rd2_q) begin
            vec_d[cap_q*DWIDTH +: DWIDTH] = rom_q;
            cap_d = cap_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            d_q    <= '0;
            cap_q  <= '0;
            rd1_q  <= 1'b0;
            rd2_q  <= 1'b0;
            addr_q <= '0;
            vec_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            d_q    <= d_d;
            cap_q  <= cap_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            addr_q <= addr_d;
            vec_q  <= vec_d;
            err_q  <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign rom_addr  = addr_q;
    assign out_vec   = vec_q;
    assign err       = err_q;

endmodule

// File: tb/tb_emb_lookup_ctrl.sv
// Scoreboard bench for emb_lookup_ctrl: a behavioural ROM plus a reference
// model that builds each expected vector straight from the ROM contents.
module tb_emb_lookup_ctrl;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int ED = 24;
    localparam int CN = 200;
    localparam int CW = 8;
    localparam int VW = ED * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_char = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic          busy;
    logic          err;

    emb_lookup_ctrl #(
        .DWIDTH  (DW),
        .AWIDTH  (AW),
        .EMB_DIM (ED),
        .CHAR_NUM(CN),
        .CWIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [8192];
    initial for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    always @(posedge clk) rom_q <= mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [VW-1:0] exp_q[$];

    bit in_rst = 1'b1;
    bit force_low = 1'b0;
    bit rnd_rdy = 1'b0;

    // monitor-side model of the token in flight
    bit            inflight = 1'b0;
    bit            have_tok = 1'b0;
    bit            seen_valid = 1'b0;
    bit            tok_oob = 1'b0;
    bit            exp_err = 1'b0;
    int            e0 = 0;
    logic [AW-1:0] tok_base = '0;
    logic [AW-1:0] exp_addr = '0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [VW-1:0] exp_vec(input int c);
        logic [VW-1:0] v;
        v = '0;
`ifdef EMB_BOUND_CHECK_EN
        if (c >= CN) return v;
`endif
        for (int d = 0; d < ED; d++) v[d*DW +: DW] = mem[(c * ED + d) % 8192];
        return v;
    endfunction

    // monitor: per-cycle handshake/address checks and scoreboard pops
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (!in_rst && rst_n) begin
                check("in_ready", in_ready, !inflight);
                check("busy", busy, inflight);
                check("err", err, exp_err);
                if (have_tok && !tok_oob) begin
                    k = cyc - e0;
                    if (k >= 1 && k <= ED) exp_addr = tok_base + AW'(k - 1);
                end
                check("rom_addr", rom_addr, exp_addr);
                if (inflight) begin
                    if (!seen_valid) begin
                        if (out_valid) begin
                            check("latency", VW'(cyc - e0), tok_oob ? VW'(0) : VW'(ED + 2));
                            seen_valid = 1'b1;
                        end else if (cyc - e0 > ED + 2) begin
                            check("out_valid_late", out_valid, 1'b1);
                            seen_valid = 1'b1;
                        end
                    end else begin
                        check("out_valid_held", out_valid, 1'b1);
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) fail_now("unexpected_output");
                        else check("out_vec", out_vec, exp_q.pop_front());
                        inflight = 1'b0;
                        seen_valid = 1'b0;
                    end
                end else begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end
                if (in_valid && in_ready) begin
                    inflight = 1'b1;
                    seen_valid = 1'b0;
                    have_tok = 1'b1;
                    e0 = cyc + 1;
                    tok_base = AW'(int'(in_char) * ED);
`ifdef EMB_BOUND_CHECK_EN
                    tok_oob = (int'(in_char) >= CN);
`else
                    tok_oob = 1'b0;
`endif
                    if (tok_oob) exp_err = 1'b1;
                end
            end
        end
    end

    // downstream ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_low ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // called at posedge+1; leaves in_valid high, returns at posedge+1 after the accept edge
    task automatic send(input logic [CW-1:0] c);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        in_valid = 1'b1;
        in_char = c;
        while (!acc && t < 500) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
            t++;
        end
        if (!acc) fail_now("accept_timeout");
        else exp_q.push_back(exp_vec(int'(c)));
        @(posedge clk);
        #1;
        in_char = CW'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_char = CW'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || inflight) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) fail_now("drain_timeout");
    endtask

    // called at posedge+1; asserts reset asynchronously between edges
    task automatic do_reset();
        in_rst = 1'b1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rom_addr", rom_addr, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_err", err, 1'b0);
        check("rst_out_vec", out_vec, '0);
        exp_q.delete();
        inflight = 1'b0;
        have_tok = 1'b0;
        seen_valid = 1'b0;
        tok_oob = 1'b0;
        exp_err = 1'b0;
        exp_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        int t;
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // first and last valid index
        send(8'd0);
        idle(1);
        wait_drain();
        send(8'd199);
        idle(0);
        wait_drain();

        // downstream stalls 10 cycles in DONE
        force_low = 1'b1;
        send(8'd5);
        idle(0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_now("stall_wait_timeout");
        for (int i = 0; i < 10; i++) begin
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_vec", out_vec, exp_vec(5));
            check("stall_rom_addr", rom_addr, AW'(5 * ED + ED - 1));
            check("stall_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        force_low = 1'b0;
        wait_drain();

        // in_valid held across two tokens
        send(8'd5);
        send(8'd6);
        idle(0);
        wait_drain();

        // reset in the middle of the read phase, then a normal token
        send(8'd10);
        repeat (10) @(posedge clk);
        #1;
        do_reset();
        idle(1);
        send(8'd3);
        idle(0);
        wait_drain();

        // first out-of-range index
        send(8'd200);
        idle(0);
        wait_drain();

        // randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(CW'($urandom_range(0, CN - 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        wait_drain();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
